// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared defaults for the sprite ROM arbiter slice.
//   NUM_REQ  : number of sprite renderers sharing the ROM
//   ADDR_W   : ROM address width
//   DATA_W   : ROM word (palette index) width
//   BURST    : max consecutive grants to one requester while others wait
//   req_id_t : requester index type sized for NUM_REQ
package sprite_rom_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned DATA_W  = 5;
    localparam int unsigned BURST   = 4;

    typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Bus between the sprite renderers, the arbiter and the external ROM.
//   req / req_addr        : per-requester level request and packed address
//   gnt                   : one-hot-or-zero grant (combinational)
//   rom_address / rom_q   : registered ROM address out, ROM data back
//   rd_valid / rd_data    : owner marker and registered ROM word
// slave  : arbiter side
// master : renderer/ROM side
interface sprite_rom_arbiter_if #(
    parameter int unsigned NUM_REQ = sprite_rom_pkg::NUM_REQ,
    parameter int unsigned ADDR_W  = sprite_rom_pkg::ADDR_W,
    parameter int unsigned DATA_W  = sprite_rom_pkg::DATA_W
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         rom_address;
    logic [DATA_W-1:0]         rom_q;
    logic [NUM_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]         rd_data;

    modport slave (
        input  req, req_addr, rom_q,
        output gnt, rom_address, rd_valid, rd_data
    );

    modport master (
        output req, req_addr, rom_q,
        input  gnt, rom_address, rd_valid, rd_data
    );

endinterface

// File: rtl/sprite_rom_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: searches req upward from ptr,
// modulo NUM_REQ, and returns the first set bit.
//   req : request vector
//   ptr : search start index
//   gnt : one-hot-or-zero winner
//   idx : winner index (0 when no request)
module rr_priority_pick #(
    parameter int unsigned NUM_REQ = sprite_rom_pkg::NUM_REQ,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx
);

    logic            found;
    logic [ID_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one external sprite ROM among NUM_REQ
// renderers, with a two-stage read pipeline (grant in N, data in N+2).
//   vga_clk : the only clock, all state on posedge
//   reset_n : asynchronous active-low reset
//   bus     : request/grant, ROM address/data and read-return signals
module sprite_rom_arbiter #(
    parameter int unsigned NUM_REQ = sprite_rom_pkg::NUM_REQ,
    parameter int unsigned ADDR_W  = sprite_rom_pkg::ADDR_W,
    parameter int unsigned DATA_W  = sprite_rom_pkg::DATA_W,
    parameter int unsigned BURST   = sprite_rom_pkg::BURST
) (
    input logic              vga_clk,
    input logic              reset_n,
    sprite_rom_arbiter_if.slave bus
);

    localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BURST_W = $clog2(BURST + 1);

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic               owner_v_q, owner_v_d;
    logic [ADDR_W-1:0]  rom_address_q, rom_address_d;
    logic [ID_W-1:0]    id1_q, id1_d;
    logic               v1_q, v1_d;
    logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0] gnt_c;
    logic [ID_W-1:0]    sel_idx;
    logic               hold;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_comb begin
        ptr_d         = ptr_q;
        burst_cnt_d   = '0;
        owner_d       = owner_q;
        owner_v_d     = 1'b0;
        gnt_c         = '0;
        sel_idx       = owner_q;
        rom_address_d = rom_address_q;
        id1_d         = id1_q;
        v1_d          = 1'b0;

        // Burst continuation overrides the pointer search; ptr was already
        // advanced past the owner when its burst started, so an ended burst
        // naturally resumes the search at owner+1.
        hold = owner_v_q && bus.req[owner_q] &&
               (burst_cnt_q < BURST_W'(BURST - 1));

        if (reset_n) begin
            if (hold) begin
                gnt_c       = NUM_REQ'(1) << owner_q;
                burst_cnt_d = burst_cnt_q + 1'b1;
                owner_v_d   = 1'b1;
            end else if (|pick_gnt) begin
                gnt_c     = pick_gnt;
                sel_idx   = pick_idx;
                owner_d   = pick_idx;
                owner_v_d = 1'b1;
                ptr_d     = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            end
        end

        if (|gnt_c) begin
            rom_address_d = bus.req_addr[32'(sel_idx)*ADDR_W +: ADDR_W];
            id1_d         = sel_idx;
            v1_d          = 1'b1;
        end

        rd_data_d  = bus.rom_q;
        rd_valid_d = v1_q ? (NUM_REQ'(1) << id1_q) : '0;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q         <= '0;
            burst_cnt_q   <= '0;
            owner_q       <= '0;
            owner_v_q     <= 1'b0;
            rom_address_q <= '0;
            id1_q         <= '0;
            v1_q          <= 1'b0;
            rd_valid_q    <= '0;
            rd_data_q     <= '0;
        end else begin
            ptr_q         <= ptr_d;
            burst_cnt_q   <= burst_cnt_d;
            owner_q       <= owner_d;
            owner_v_q     <= owner_v_d;
            rom_address_q <= rom_address_d;
            id1_q         <= id1_d;
            v1_q          <= v1_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign bus.gnt         = gnt_c;
    assign bus.rom_address = rom_address_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
module tb_sprite_rom_arbiter;
    import sprite_rom_pkg::*;

    localparam int unsigned AWT = NUM_REQ * ADDR_W;

    logic vga_clk = 1'b0;
    logic reset_n;

    sprite_rom_arbiter_if #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) bus ();

    sprite_rom_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .BURST   (BURST)
    ) dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 vga_clk = ~vga_clk;

    // External ROM: samples rom_address on the negedge.
    logic [DATA_W-1:0] rom [0:(1<<ADDR_W)-1];
    always @(negedge vga_clk) bus.rom_q <= rom[bus.rom_address];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: run-length view of the arbitration rules plus a
    // two-deep queue of outstanding reads.
    int          m_ptr, m_owner, m_run;
    bit          m_own_v;
    int unsigned m_rom_addr;
    bit          s1_v, s2_v;
    int          s1_id, s2_id;
    int unsigned s1_addr, s2_addr;

    logic [NUM_REQ-1:0] last_gnt, last_rd_valid;
    logic [ADDR_W-1:0]  last_rom_addr;
    logic [DATA_W-1:0]  last_rd_data;

    typedef struct {
        logic [NUM_REQ-1:0] req;
        logic [NUM_REQ-1:0] gnt;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_run = 0; m_own_v = 0; m_rom_addr = 0;
        s1_v = 0; s2_v = 0; s1_id = 0; s2_id = 0; s1_addr = 0; s2_addr = 0;
    endtask

    function automatic int model_pick(input logic [NUM_REQ-1:0] r);
        if (m_own_v && r[m_owner] && m_run < int'(BURST)) return m_owner;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            int j = (m_ptr + k) % int'(NUM_REQ);
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic int unsigned slice_of(input logic [AWT-1:0] ra, input int w);
        logic [ADDR_W-1:0] a;
        a = ra[w*ADDR_W +: ADDR_W];
        return int'(a);
    endfunction

    task automatic model_advance(input int w, input logic [AWT-1:0] ra);
        s2_v = s1_v; s2_id = s1_id; s2_addr = s1_addr;
        if (w >= 0) begin
            if (m_own_v && w == m_owner && m_run < int'(BURST)) begin
                m_run++;
            end else begin
                m_run   = 1;
                m_owner = w;
                m_ptr   = (w + 1) % int'(NUM_REQ);
            end
            m_own_v    = 1;
            s1_v       = 1;
            s1_id      = w;
            s1_addr    = slice_of(ra, w);
            m_rom_addr = s1_addr;
        end else begin
            m_own_v = 0;
            m_run   = 0;
            s1_v    = 0;
        end
    endtask

    // Entered at posedge+1 with inputs applied; checks at the negedge,
    // advances the model and returns at the next posedge+1.
    task automatic run_cycle();
        int w;
        logic [NUM_REQ-1:0] eg, ev;
        @(negedge vga_clk);
        w  = model_pick(bus.req);
        eg = (w >= 0) ? (NUM_REQ'(1) << w) : '0;
        ev = s2_v ? (NUM_REQ'(1) << s2_id) : '0;
        last_gnt      = bus.gnt;
        last_rd_valid = bus.rd_valid;
        last_rom_addr = bus.rom_address;
        last_rd_data  = bus.rd_data;
        chk("gnt", 32'(bus.gnt), 32'(eg));
        chk("rom_address", 32'(bus.rom_address), m_rom_addr);
        chk("rd_valid", 32'(bus.rd_valid), 32'(ev));
        if (s2_v) chk("rd_data", 32'(bus.rd_data), 32'(rom[s2_addr]));
        model_advance(w, bus.req_addr);
        @(posedge vga_clk);
        #1;
    endtask

    function automatic logic [AWT-1:0] rand_addrs();
        return AWT'({$urandom(), $urandom()});
    endfunction

    // Entered at posedge+1; requests are held high to show they are ignored.
    task automatic do_reset();
        reset_n = 1'b0;
        bus.req = '1;
        bus.req_addr = rand_addrs();
        #3;
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_rom_address", 32'(bus.rom_address), 32'd0);
        @(posedge vga_clk);
        #1;
        reset_n = 1'b1;
        bus.req = '0;
        model_reset();
    endtask

    initial begin
        int pulses;
        logic [NUM_REQ-1:0] rv_hist [5];
        logic [ADDR_W-1:0]  ra_hist [5];
        logic [AWT-1:0]     ra;
        logic [ADDR_W-1:0]  a15;

        for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = DATA_W'($urandom());
        rom[9'h015] = 5'h0A;

        for (int i = 0; i < 17; i++)
            tbl.push_back('{4'b1111, NUM_REQ'(1) << ((i / 4) % 4)});
        tbl.push_back('{4'b0100, 4'b0100});
        for (int i = 0; i < 9; i++)
            tbl.push_back('{4'b1001, (i >= 4 && i < 8) ? 4'b0001 : 4'b1000});

        reset_n = 1'b1;
        bus.req = '0;
        bus.req_addr = '0;
        @(posedge vga_clk);
        #1;
        do_reset();

        // Burst/wrap and two-requester round robin
        for (int i = 0; i < tbl.size(); i++) begin
            bus.req = tbl[i].req;
            bus.req_addr = rand_addrs();
            run_cycle();
            chk("tbl_gnt", 32'(last_gnt), 32'(tbl[i].gnt));
        end

        // Single read latency: requester 2, address 0x15
        do_reset();
        ra  = rand_addrs();
        a15 = 9'h015;
        ra[2*ADDR_W +: ADDR_W] = a15;
        bus.req = 4'b0100;
        bus.req_addr = ra;
        run_cycle();
        chk("lat_gnt", 32'(last_gnt), 32'h4);
        bus.req = '0;
        bus.req_addr = rand_addrs();
        run_cycle();
        chk("lat_rom_address", 32'(last_rom_addr), 32'h15);
        run_cycle();
        chk("lat_rd_valid", 32'(last_rd_valid), 32'h4);
        chk("lat_rd_data", 32'(last_rd_data), 32'h0A);

        // Lone requester held for 10 cycles
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            bus.req = (i < 10) ? 4'b0010 : 4'b0000;
            bus.req_addr = rand_addrs();
            run_cycle();
            if (i < 10) chk("solo_gnt", 32'(last_gnt), 32'h2);
            if (last_rd_valid == 4'b0010) pulses++;
        end
        chk("solo_pulses", 32'(pulses), 32'd10);

        // Bubble: requester 0 toggles 1,0,1
        for (int i = 0; i < 5; i++) begin
            bus.req = (i == 0 || i == 2) ? 4'b0001 : 4'b0000;
            bus.req_addr = rand_addrs();
            run_cycle();
            rv_hist[i] = last_rd_valid;
            ra_hist[i] = last_rom_addr;
        end
        chk("bubble_rv2", 32'(rv_hist[2]), 32'h1);
        chk("bubble_rv3", 32'(rv_hist[3]), 32'h0);
        chk("bubble_rv4", 32'(rv_hist[4]), 32'h1);
        chk("bubble_addr_hold", 32'(ra_hist[2]), 32'(ra_hist[1]));

        // Reset with two reads in flight
        bus.req = 4'b0010;
        bus.req_addr = rand_addrs();
        run_cycle();
        run_cycle();
        do_reset();
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            bus.req = '0;
            bus.req_addr = rand_addrs();
            run_cycle();
            if (last_rd_valid != '0) pulses++;
        end
        chk("flush_pulses", 32'(pulses), 32'd0);
        bus.req = 4'b1111;
        bus.req_addr = rand_addrs();
        run_cycle();
        chk("post_reset_gnt", 32'(last_gnt), 32'h1);

        // Randomised traffic, requests often held to exercise bursts
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) bus.req = NUM_REQ'($urandom());
            bus.req_addr = rand_addrs();
            run_cycle();
        end
        bus.req = '0;
        run_cycle();
        run_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
